// File: rtl/fb_bram_arbiter.sv
// Frame-buffer BRAM arbiter: TX reads take the port with absolute priority,
// RX writes are buffered in a small FIFO, and a full-buffer clear can be sequenced.
module fb_bram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int FB_WORDS   = 16384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_rd_en,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0] tx_dout,
    output logic              tx_dvalid,
    input  logic              rx_wr_valid,
    output logic              rx_wr_ready,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_din,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              overflow,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic              bram_re,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_din;
    logic              run;
    logic              push, pop, clr_adv, flush;

    // run keeps the FIFO closed until the first edge after reset release
    assign rx_wr_ready = run && (state == IDLE) && (count < FULL_CNT);
    assign flush       = (state == IDLE) && clear_req;
    assign push        = rx_wr_valid && rx_wr_ready && !clear_req;
    assign clear_busy  = (state == CLEAR);
    assign tx_dout     = bram_dout;

    always_comb begin
        bram_re    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = last_addr;
        bram_din   = last_din;
        pop        = 1'b0;
        clr_adv    = 1'b0;
        state_next = state;
        // Grants are suppressed while reset is held so the BRAM is never touched
        if (reset_n) begin
            if (tx_rd_en) begin
                bram_re   = 1'b1;
                bram_addr = tx_addr;
            end else if (state == CLEAR) begin
                bram_we   = 1'b1;
                bram_addr = clr_cnt;
                bram_din  = '0;
                clr_adv   = 1'b1;
            end else if ((count != '0) && !clear_req) begin
                bram_we   = 1'b1;
                bram_addr = fifo_addr[rd_ptr];
                bram_din  = fifo_data[rd_ptr];
                pop       = 1'b1;
            end
        end
        if (state == IDLE) begin
            if (clear_req) state_next = CLEAR;
        end else begin
            if (clr_adv && (clr_cnt == CLR_LAST)) state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= rx_addr;
            fifo_data[wr_ptr] <= rx_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            tx_dvalid <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            clr_cnt   <= '0;
            last_addr <= '0;
            last_din  <= '0;
        end else begin
            state     <= state_next;
            run       <= 1'b1;
            tx_dvalid <= tx_rd_en;
            last_addr <= bram_addr;
            last_din  <= bram_din;
            if ((state == IDLE) && rx_wr_valid && (count == FULL_CNT)) overflow <= 1'b1;
            // Entering a clear discards anything still queued
            if (flush) begin
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                clr_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
                if (clr_adv) clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Scoreboard bench for fb_bram_arbiter: stimulus queues expected reads/writes,
// a negedge monitor pops and compares whenever the DUT reads or writes the BRAM.
module tb_fb_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_rd_en = 1'b0;
    logic [13:0] tx_addr = '0;
    logic [7:0]  tx_dout;
    logic        tx_dvalid;
    logic        rx_wr_valid = 1'b0;
    logic        rx_wr_ready;
    logic [13:0] rx_addr = '0;
    logic [7:0]  rx_din = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        overflow;
    logic [13:0] bram_addr;
    logic [7:0]  bram_din;
    logic        bram_we;
    logic        bram_re;
    logic [7:0]  bram_dout;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    bit [7:0] mem [16384];
    bit       written [16384];

    fb_bram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .tx_rd_en(tx_rd_en), .tx_addr(tx_addr), .tx_dout(tx_dout), .tx_dvalid(tx_dvalid),
        .rx_wr_valid(rx_wr_valid), .rx_wr_ready(rx_wr_ready), .rx_addr(rx_addr), .rx_din(rx_din),
        .clear_req(clear_req), .clear_busy(clear_busy), .overflow(overflow),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_re(bram_re),
        .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // BRAM model: unwritten words read back as (addr low byte + 0x10)
    always @(posedge clk) begin
        if (bram_we) begin
            mem[bram_addr]     <= bram_din;
            written[bram_addr] <= 1'b1;
        end
        if (bram_re)
            bram_dout <= written[bram_addr] ? mem[bram_addr] : bram_addr[7:0] + 8'h10;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wpair(input logic [13:0] a, input logic [7:0] d);
        return {10'd0, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (tx_dvalid) begin
            if (exp_rd.size() == 0) check_output("rd_spurious", 32'(tx_dvalid), 32'd0);
            else check_output("rd_data", 32'(tx_dout), exp_rd.pop_front());
        end
        if (bram_we) begin
            if (exp_wr.size() == 0) check_output("wr_spurious", 32'(bram_we), 32'd0);
            else check_output("wr_pair", wpair(bram_addr, bram_din), exp_wr.pop_front());
        end
    end

    initial begin
        int n;

        // reset state
        repeat (2) step();
        check_output("rst_dvalid", 32'(tx_dvalid), 32'd0);
        check_output("rst_ready", 32'(rx_wr_ready), 32'd0);
        check_output("rst_busy", 32'(clear_busy), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_we_re", {30'd0, bram_we, bram_re}, 32'd0);
        check_output("rst_addr_din", wpair(bram_addr, bram_din), 32'd0);
        reset_n = 1'b1;
        step();
        check_output("ready_after_rst", 32'(rx_wr_ready), 32'd1);

        // back-to-back TX reads of 0..3
        for (int i = 0; i < 4; i++) begin
            tx_rd_en = 1'b1;
            tx_addr  = 14'(i);
            exp_rd.push_back(32'(16 + i));
            step();
            check_output("rd_latency", 32'(tx_dvalid), 32'd1);
        end
        tx_rd_en = 1'b0;
        step();
        check_output("rd_dvalid_drop", 32'(tx_dvalid), 32'd0);
        check_output("rd_drain", 32'(exp_rd.size()), 32'd0);

        // two RX writes with TX idle, then read them back
        rx_wr_valid = 1'b1;
        rx_addr = 14'h0100; rx_din = 8'hAA;
        check_output("wr_ready0", 32'(rx_wr_ready), 32'd1);
        exp_wr.push_back(wpair(14'h0100, 8'hAA));
        step();
        check_output("wr_latency", {17'd0, bram_we, bram_addr}, {17'd0, 1'b1, 14'h0100});
        rx_addr = 14'h0101; rx_din = 8'hBB;
        check_output("wr_ready1", 32'(rx_wr_ready), 32'd1);
        exp_wr.push_back(wpair(14'h0101, 8'hBB));
        step();
        rx_wr_valid = 1'b0;
        step();
        check_output("wr_drain", 32'(exp_wr.size()), 32'd0);
        tx_rd_en = 1'b1; tx_addr = 14'h0100; exp_rd.push_back(32'hAA);
        step();
        tx_addr = 14'h0101; exp_rd.push_back(32'hBB);
        step();
        tx_rd_en = 1'b0;
        step();

        // FIFO fill under TX contention, overflow, then drain
        for (int i = 0; i < 5; i++) begin
            tx_rd_en = 1'b1; tx_addr = 14'h0004; exp_rd.push_back(32'h14);
            rx_wr_valid = 1'b1; rx_addr = 14'(16'h0200 + i); rx_din = 8'(8'h30 + i);
            check_output("fill_ready", 32'(rx_wr_ready), (i < 4) ? 32'd1 : 32'd0);
            if (i == 4) check_output("ovf_before", 32'(overflow), 32'd0);
            step();
        end
        rx_wr_valid = 1'b0;
        exp_rd.push_back(32'h14);
        check_output("ovf_set", 32'(overflow), 32'd1);
        check_output("full_ready", 32'(rx_wr_ready), 32'd0);
        step();
        tx_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) exp_wr.push_back(wpair(14'(16'h0200 + i), 8'(8'h30 + i)));
        repeat (4) step();
        check_output("fifo_drain4", 32'(exp_wr.size()), 32'd0);
        check_output("ready_after_drain", 32'(rx_wr_ready), 32'd1);

        // reset in the middle of a clear, once clr_cnt reaches 0x0800
        clear_req = 1'b1;
        for (int i = 0; i < 16'h0800; i++) exp_wr.push_back(wpair(14'(i), 8'h00));
        step();
        clear_req = 1'b0;
        n = 0;
        while (exp_wr.size() != 0 && n < 5000) begin
            n++;
            step();
        end
        check_output("clr_reach_800", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
        reset_n = 1'b0;
        tx_rd_en = 1'b1; tx_addr = 14'h0007;
        #1;
        check_output("mid_rst_busy", 32'(clear_busy), 32'd0);
        check_output("mid_rst_overflow", 32'(overflow), 32'd0);
        check_output("mid_rst_ready", 32'(rx_wr_ready), 32'd0);
        check_output("mid_rst_we_re", {30'd0, bram_we, bram_re}, 32'd0);
        check_output("mid_rst_addr_din", wpair(bram_addr, bram_din), 32'd0);
        step();
        step();
        check_output("mid_rst_dvalid", 32'(tx_dvalid), 32'd0);
        tx_rd_en = 1'b0;
        reset_n = 1'b1;
        step();
        check_output("post_rst_ready", 32'(rx_wr_ready), 32'd1);
        check_output("post_rst_busy", 32'(clear_busy), 32'd0);
        rx_wr_valid = 1'b1; rx_addr = 14'h0400; rx_din = 8'h5C;
        exp_wr.push_back(wpair(14'h0400, 8'h5C));
        step();
        rx_wr_valid = 1'b0;
        step();
        check_output("post_rst_write", 32'(exp_wr.size()), 32'd0);
        tx_rd_en = 1'b1; tx_addr = 14'h0400; exp_rd.push_back(32'h5C);
        step();
        tx_rd_en = 1'b0;
        step();

        // clear stretched by 10 TX reads; RX offers ignored
        clear_req = 1'b1;
        for (int i = 0; i < 16384; i++) exp_wr.push_back(wpair(14'(i), 8'h00));
        step();
        clear_req = 1'b0;
        check_output("clr_busy_entry", 32'(clear_busy), 32'd1);
        rx_wr_valid = 1'b1; rx_addr = 14'h0500; rx_din = 8'hEE;
        n = 0;
        while (clear_busy && n < 20000) begin
            if (n < 10) begin
                tx_rd_en = 1'b1;
                tx_addr  = 14'(16'h3F00 + n);
                exp_rd.push_back(32'(16 + n));
            end else begin
                tx_rd_en = 1'b0;
            end
            n++;
            step();
        end
        rx_wr_valid = 1'b0;
        tx_rd_en = 1'b0;
        check_output("clr_stretch_len", 32'(n), 32'd16394);
        check_output("clr_stretch_writes", 32'(exp_wr.size()), 32'd0);
        check_output("clr_no_overflow", 32'(overflow), 32'd0);
        check_output("clr_ready_after", 32'(rx_wr_ready), 32'd1);
        step();

        // clear request flushes two pending entries
        for (int i = 0; i < 2; i++) begin
            tx_rd_en = 1'b1; tx_addr = 14'h0000; exp_rd.push_back(32'h00);
            rx_wr_valid = 1'b1; rx_addr = 14'(16'h0300 + i); rx_din = 8'(8'h77 + 8'(i) * 8'h11);
            step();
        end
        rx_wr_valid = 1'b0;
        tx_rd_en = 1'b0;
        clear_req = 1'b1;
        for (int i = 0; i < 16384; i++) exp_wr.push_back(wpair(14'(i), 8'h00));
        step();
        clear_req = 1'b0;
        n = 0;
        while (clear_busy && n < 20000) begin
            n++;
            step();
        end
        check_output("clr_len", 32'(n), 32'd16384);
        check_output("clr_writes", 32'(exp_wr.size()), 32'd0);
        step();
        check_output("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        check_output("final_wr_queue", 32'(exp_wr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
